muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the ID-stage register file. It consumes the two register read operands (rs1/rs2 data) plus funct3 and produces the 32-bit M-extension result. While it runs, it holds the pipeline through `busy`. Multiplies are two-edge; divides and remainders use a 32-step restoring divider.

## Interface
- No parameters; the datapath is fixed at XLEN = 32.
- `clk` input 1 — clock, rising edge.
- `rst` input 1 — reset, synchronous, active-high.
- `start` input 1 — request; sampled only when `busy` = 0.
- `op` input 3 — RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1_data` input 32 — operand A / dividend.
- `rs2_data` input 32 — operand B / divisor.
- `flush` input 1 — abort the current operation (branch mispredict/trap).
- `busy` output 1 — operation in flight; stalls IF/ID/EX.
- `valid` output 1 — one-cycle pulse; `result` is meaningful while it is high.
- `result` output 32 — registered result; held until the next `valid`.

## Operation
- FSM states:
  - IDLE: `busy` = 0.
  - MUL: one edge.
  - DIV: 32 iteration edges.
  - FIN: one edge for sign fix-up and result write.
- `busy` is decoded combinationally as `state != IDLE`.
- IDLE + `start`, selected by `op[2]`:
  - `op[2]` = 0: latch operands, go to MUL.
  - `op[2]` = 1, divisor = 0: go to FIN with a preloaded result. Quotient = 0xFFFFFFFF; remainder = dividend.
  - `op[2]` = 1, signed op with dividend 0x80000000 and divisor 0xFFFFFFFF: go to FIN with a preloaded result. Quotient = 0x80000000; remainder = 0.
  - Any other divide: load |A| and |B| (absolute values only for signed ops), clear the count, go to DIV.
- MUL state:
  - Form the 33x33 signed product of extended operands. A is sign-extended for MUL/MULH/MULHSU. B is sign-extended for MUL/MULH only; otherwise operands are zero-extended.
  - MUL returns product[31:0]; the other three return product[63:32].
  - Write `result`, pulse `valid`, go to IDLE.
- DIV state, one restoring step per edge:
  - Shift {rem, quo} left by 1.
  - Trial-subtract the divisor from rem[32:0].
  - If non-negative, keep the difference and set the quotient LSB.
  - After 32 steps (count = 31 on the last edge), go to FIN.
- FIN state:
  - Signed divide: negate the quotient if the operand signs differ; negate the remainder if the dividend is negative.
  - Select the quotient (DIV/DIVU) or remainder (REM/REMU).
  - Write `result`, pulse `valid`, go to IDLE.
- `start` while `busy` = 1 is ignored; ID holds the instruction under stall.
- `flush` in any state: next edge goes to IDLE, `valid` = 0, `result` unchanged. `flush` has priority over `start` in the same cycle.
- All arithmetic is modulo 2^32 on outputs. Divide internals are 33-bit for the trial subtract.

## Timing
- E0 is the edge that samples `start` with `busy` = 0.
- Latency:
  - Multiply: `valid` is registered at E1, so it is high in the cycle after E1.
  - Divide by zero and signed overflow: `valid` at E1.
  - Normal divide/remainder: `valid` at E33 (32 steps plus FIN).
- `busy` is high from E0 until the edge that sets `valid`. In the `valid` cycle, `busy` = 0, so back-to-back `start` is legal in that same cycle.
- `valid` is high for exactly one cycle per accepted operation.
- Reset values: state = IDLE, `busy` = 0, `valid` = 0, `result` = 0x00000000, count = 0.
- `rst` mid-operation: abandons the operation at that edge, with no `valid` afterwards.
- Operands are latched at E0; later changes on `rs1_data`/`rs2_data` have no effect.

## Structure
- Package `muldiv_pkg`:
  - funct3 op constants (`OP_MUL` … `OP_REMU`).
  - FSM state encoding (IDLE/MUL/DIV/FIN).
  - `XLEN` = 32, `DIV_STEPS` = 32.
- Sub-module `div_core` holds the iterative restoring divider:
  - Inputs: `load`, `step`, unsigned dividend and divisor.
  - Outputs: `quo`, `rem`, `last`.
- The top level owns the FSM, special-case detection, sign handling, the multiplier, and the output register.

## Test plan
- MUL, A = 7, B = 0xFFFFFFFD (-3) -> `result` 0xFFFFFFEB with `valid` at E1; `busy` high for exactly one cycle.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7 / 2 -> 0xFFFFFFFD and REM -7 / 2 -> 0xFFFFFFFF, each with `valid` at E33. DIVU 100 / 7 -> 14; REMU -> 2.
- DIV 0x12345678 / 0 -> 0xFFFFFFFF; REMU 0x12345678 / 0 -> 0x12345678; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same -> 0. All four with `valid` at E1.
- `flush` asserted at E10 of a DIV -> `busy` low after E10, no `valid` ever; `result` keeps its prior value. A following MUL completes normally.
- `rst` held at E5 of a divide -> `busy` = 0, `valid` = 0, `result` = 0. A `start` in the `valid` cycle of a prior op is accepted (back-to-back), and a `start` while `busy` is ignored.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared constants for the RV32M multiply/divide unit: funct3 codes, FSM states, widths.
// Combinational definitions only; no latency and no flow control.
package muldiv_pkg;
  localparam int XLEN      = 32;
  localparam int DIV_STEPS = 32;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIN  = 2'd3
  } state_e;
endpackage

// File: rtl/muldiv_unit_if.sv
// EX-stage request/result bundle between the pipeline and the muldiv unit.
// The pipeline holds its request steady while busy is high; valid is a one-cycle pulse.
interface muldiv_unit_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        busy;
  logic        valid;
  logic [31:0] result;

  modport master (output start, op, rs1_data, rs2_data, flush,
                  input  busy, valid, result);
  modport slave  (input  start, op, rs1_data, rs2_data, flush,
                  output busy, valid, result);
endinterface

// File: rtl/muldiv_unit_div_core.sv
// Unsigned restoring divider: one quotient bit per step; quo/rem are final after 32 steps.
// load restarts it; last flags the step that produces the final bit.
module div_core
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic            i_step,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_quo,
  output logic [XLEN-1:0] o_rem,
  output logic            o_last
);
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_div;
  logic [4:0]      r_cnt;
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_diff;

  // Partial remainder stays below the divisor, so a 33-bit difference never overflows.
  assign w_shift = {r_rem, r_quo[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, r_div};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_quo <= '0;
      r_rem <= '0;
      r_div <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_quo <= i_dividend;
      r_rem <= '0;
      r_div <= i_divisor;
      r_cnt <= '0;
    end else if (i_step) begin
      r_cnt <= r_cnt + 5'd1;
      if (!w_diff[XLEN]) begin
        r_rem <= w_diff[XLEN-1:0];
        r_quo <= {r_quo[XLEN-2:0], 1'b1};
      end else begin
        r_rem <= w_shift[XLEN-1:0];
        r_quo <= {r_quo[XLEN-2:0], 1'b0};
      end
    end
  end

  assign o_quo  = r_quo;
  assign o_rem  = r_rem;
  assign o_last = (r_cnt == 5'(DIV_STEPS - 1));
endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide: MUL family and divide special cases in 1 edge, normal divides in 33.
// busy stalls the pipeline while in flight; flush or rst abandons the operation without valid.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  muldiv_unit_if.slave bus
);
  state_e          r_state;
  logic [2:0]      r_op;
  logic [XLEN-1:0] r_a, r_b, r_pre, r_result;
  logic            r_special, r_neg_q, r_neg_r, r_valid;

  logic            w_signed_div, w_div0, w_ovf, w_load, w_step, w_last;
  logic [XLEN-1:0] w_abs_a, w_abs_b, w_quo, w_rem, w_quo_fix, w_rem_fix, w_mul_res;
  logic [XLEN:0]   w_a_ext, w_b_ext;
  logic [63:0]     w_prod;

  assign w_signed_div = ~bus.op[0];
  assign w_div0       = (bus.rs2_data == '0);
  assign w_ovf        = w_signed_div && (bus.rs1_data == 32'h8000_0000) && (bus.rs2_data == '1);
  assign w_abs_a      = (w_signed_div && bus.rs1_data[XLEN-1]) ? -bus.rs1_data : bus.rs1_data;
  assign w_abs_b      = (w_signed_div && bus.rs2_data[XLEN-1]) ? -bus.rs2_data : bus.rs2_data;
  assign w_load       = (r_state == S_IDLE) && bus.start && !bus.flush && bus.op[2] && !w_div0 && !w_ovf;
  assign w_step       = (r_state == S_DIV) && !bus.flush;

  div_core u_div (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_step     (w_step),
    .i_dividend (w_abs_a),
    .i_divisor  (w_abs_b),
    .o_quo      (w_quo),
    .o_rem      (w_rem),
    .o_last     (w_last)
  );

  // 33x33 signed product; computing it 64 bits wide keeps every bit of the result used.
  assign w_a_ext   = {(r_op != OP_MULHU) & r_a[XLEN-1], r_a};
  assign w_b_ext   = {~r_op[1] & r_b[XLEN-1], r_b};
  assign w_prod    = {{31{w_a_ext[XLEN]}}, w_a_ext} * {{31{w_b_ext[XLEN]}}, w_b_ext};
  assign w_mul_res = (r_op == OP_MUL) ? w_prod[31:0] : w_prod[63:32];
  assign w_quo_fix = r_neg_q ? -w_quo : w_quo;
  assign w_rem_fix = r_neg_r ? -w_rem : w_rem;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_pre     <= '0;
      r_result  <= '0;
      r_special <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (bus.flush) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: if (bus.start) begin
            r_op      <= bus.op;
            r_a       <= bus.rs1_data;
            r_b       <= bus.rs2_data;
            r_special <= 1'b0;
            r_neg_q   <= w_signed_div & (bus.rs1_data[XLEN-1] ^ bus.rs2_data[XLEN-1]);
            r_neg_r   <= w_signed_div & bus.rs1_data[XLEN-1];
            if (!bus.op[2]) begin
              r_state <= S_MUL;
            end else if (w_div0) begin
              r_special <= 1'b1;
              r_pre     <= bus.op[1] ? bus.rs1_data : '1;
              r_state   <= S_FIN;
            end else if (w_ovf) begin
              r_special <= 1'b1;
              r_pre     <= bus.op[1] ? '0 : 32'h8000_0000;
              r_state   <= S_FIN;
            end else begin
              r_state <= S_DIV;
            end
          end
          S_MUL: begin
            r_result <= w_mul_res;
            r_valid  <= 1'b1;
            r_state  <= S_IDLE;
          end
          S_DIV: if (w_last) r_state <= S_FIN;
          S_FIN: begin
            r_result <= r_special ? r_pre : (r_op[1] ? w_rem_fix : w_quo_fix);
            r_valid  <= 1'b1;
            r_state  <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.busy   = (r_state != S_IDLE);
  assign bus.valid  = r_valid;
  assign bus.result = r_result;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic reference model plus a per-cycle checker
// of busy/valid/result timing, with hand-computed literals pinning the model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  muldiv_unit_if bus ();
  muldiv_unit dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    int          e0;
    int          due;
    logic [31:0] res;
  } ent_t;

  ent_t        q[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_mis = 0;
  logic        chk_en = 1'b0;
  logic [31:0] exp_res = '0;

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      p;
    logic [63:0] u;
    int          sa, sb;
    sa = a;
    sb = b;
    p  = 0;
    u  = '0;
    case (op)
      OP_MUL:    begin p = longint'(sa) * longint'(sb); return p[31:0]; end
      OP_MULH:   begin p = longint'(sa) * longint'(sb); return p[63:32]; end
      OP_MULHSU: begin p = longint'(sa) * longint'({32'b0, b}); return p[63:32]; end
      OP_MULHU:  begin u = {32'b0, a} * {32'b0, b}; return u[63:32]; end
      OP_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return sa / sb;
      end
      OP_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return sa % sb;
      end
      OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model of abandonment: an edge sampling rst or flush drops the pending operation.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      q.delete();
      exp_res = '0;
    end else if (bus.flush) begin
      q.delete();
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic ev, eb;
      ev = (q.size() > 0) && (q[0].due == cyc);
      eb = (q.size() > 0) && (cyc >= q[0].e0) && (cyc < q[0].due);
      check("valid", 32'(bus.valid), 32'(ev));
      check("busy", 32'(bus.busy), 32'(eb));
      if (ev) begin
        exp_res = q[0].res;
        void'(q.pop_front());
      end
      check("result", bus.result, exp_res);
    end
  end

  // Called at a negedge; drives start for one cycle and records the expected completion.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] lit, output int due);
    ent_t e;
    int   lat;
    check("model_literal", model(op, a, b), lit);
    lat = (!op[2] || b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 33;
    e.e0  = cyc + 1;
    e.due = cyc + 1 + lat;
    e.res = model(op, a, b);
    q.push_back(e);
    due = e.due;
    bus.start    = 1'b1;
    bus.op       = op;
    bus.rs1_data = a;
    bus.rs2_data = b;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.rs1_data = $urandom;
    bus.rs2_data = $urandom;
  endtask

  task automatic wait_done();
    int n = 0;
    while (q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      n_cmp++;
      n_mis++;
      $display("FAIL timeout: %0d operations still pending after %0d cycles", q.size(), n);
      q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int d;
    bus.start = 1'b0; bus.op = '0; bus.rs1_data = '0; bus.rs2_data = '0; bus.flush = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_valid", 32'(bus.valid), 32'd0);
    check("reset_result", bus.result, 32'h0);

    issue(OP_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, d); wait_done();
    issue(OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, d); wait_done();
    issue(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, d); wait_done();
    issue(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, d); wait_done();
    issue(OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, d); wait_done();
    issue(OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, d); wait_done();
    issue(OP_DIVU,   32'd100,       32'd7,         32'd14,        d); wait_done();
    issue(OP_REMU,   32'd100,       32'd7,         32'd2,         d); wait_done();
    issue(OP_DIV,    32'h1234_5678, 32'h0,         32'hFFFF_FFFF, d); wait_done();
    issue(OP_REMU,   32'h1234_5678, 32'h0,         32'h1234_5678, d); wait_done();
    issue(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, d); wait_done();
    issue(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         d); wait_done();
    issue(OP_REM,    32'd20,        32'hFFFF_FFFA, 32'd2,         d); wait_done();

    // Flush sampled at E10 of a divide: no valid, result keeps its prior value.
    issue(OP_DIVU, 32'd1000, 32'd3, 32'd333, d);
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    repeat (40) @(negedge clk);
    issue(OP_MUL, 32'd12, 32'd11, 32'd132, d); wait_done();

    // Flush wins over start in the same idle cycle.
    bus.start = 1'b1; bus.op = OP_MUL; bus.rs1_data = 32'd3; bus.rs2_data = 32'd3; bus.flush = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    repeat (3) @(negedge clk);

    // Start while busy is ignored; operand changes after E0 have no effect.
    issue(OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, d);
    bus.start = 1'b1; bus.op = OP_MUL; bus.rs1_data = 32'd5; bus.rs2_data = 32'd5;
    repeat (3) @(negedge clk);
    bus.start = 1'b0;
    wait_done();

    // Back-to-back: next start issued in the valid cycle of the previous operation.
    issue(OP_DIVU, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, d);
    repeat (d - cyc) @(negedge clk);
    issue(OP_REMU, 32'hFFFF_FFFF, 32'h10, 32'hF, d);
    repeat (d - cyc) @(negedge clk);
    issue(OP_MULHU, 32'h0001_0000, 32'h0001_0000, 32'h1, d);
    repeat (d - cyc) @(negedge clk);
    issue(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, d);
    wait_done();

    // Reset sampled at E5 of a divide: operation abandoned, result cleared.
    issue(OP_DIVU, 32'd999, 32'd10, 32'd99, d);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    check("rst_mid_valid", 32'(bus.valid), 32'd0);
    check("rst_mid_result", bus.result, 32'h0);
    repeat (40) @(negedge clk);
    issue(OP_REM, 32'd17, 32'd5, 32'd2, d); wait_done();

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
